// File: rtl/seq_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_mult_pkg
// Description : Shared types and constants for the sequential shift-and-add
//               multiplier (seq_mult_unit). Provides the FSM state type,
//               width helpers and the default-width derived constants.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_mult_pkg;

    // FSM state encoding shared by the unit and anything that inspects it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width for a given operand width. One bit is the floor so a
    // WIDTH of 2 still gets a usable counter.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    // Constants for the default 8-bit configuration.
    localparam int DEFAULT_WIDTH = 8;
    localparam int PROD_W        = 2 * DEFAULT_WIDTH;
    localparam int CNT_W         = cnt_width(DEFAULT_WIDTH);

endpackage : seq_mult_pkg
`default_nettype wire

// File: rtl/seq_mult_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_mult_unit_if
// Description : start/busy/done handshake bundle between a controller and
//               seq_mult_unit.
//   start   : controller -> unit, operation request
//   a, b    : controller -> unit, multiplicand / multiplier (WIDTH bits)
//   busy    : unit -> controller, high while multiplying
//   done    : unit -> controller, one-cycle pulse with valid product
//   product : unit -> controller, 2*WIDTH-bit result register
//   master modport : controller side; slave modport : multiplier side.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_mult_unit_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output product
    );
endinterface : seq_mult_unit_if
`default_nettype wire

// File: rtl/seq_mult_unit_pp_and_row.sv
`default_nettype none
// ============================================================================
// Module      : pp_and_row
// Description : Combinational partial-product row: W two-input AND gates
//               gating a vector with a single enable bit.
//   i_vec : W-bit vector to gate (shifted multiplicand)
//   i_en  : enable (current multiplier LSB)
//   o_pp  : gated partial product
// Revision    : 1.0 - initial release
// ============================================================================
module pp_and_row #(
    parameter int W = 16
) (
    input  wire logic [W-1:0] i_vec,
    input  wire logic         i_en,
    output logic      [W-1:0] o_pp
);

    for (genvar g = 0; g < W; g++) begin : g_and
        assign o_pp[g] = i_vec[g] & i_en;
    end

endmodule : pp_and_row
`default_nettype wire

// File: rtl/seq_mult_unit.sv
`default_nettype none
// ============================================================================
// Module      : seq_mult_unit
// Description : Multi-cycle unsigned shift-and-add multiplier. One partial
//               product per cycle is accumulated into a 2*WIDTH-bit
//               accumulator; a start/busy/done handshake frames each job.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (aborts any job in flight)
//   bus  : seq_mult_unit_if.slave (start, a, b, busy, done, product)
// Parameters  : WIDTH - operand width, 2..32; product is 2*WIDTH bits.
// Options     : SEQ_MULT_EARLY_EXIT_EN - when defined, a job also finishes
//               on the edge where the remaining multiplier bits become zero
//               (latency = msb_index(b)+1, min 1). Undefined: fixed WIDTH
//               cycles and no zero-detect logic.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mult_unit
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic      clk,
    input  wire logic      rst,
    seq_mult_unit_if.slave bus
);

    localparam int                 c_PROD_W = 2 * WIDTH;
    localparam int                 c_CNT_W  = cnt_width(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST   = c_CNT_W'(WIDTH - 1);

    state_t               r_state;
    logic [c_PROD_W-1:0]  r_mcand;
    logic [WIDTH-1:0]     r_mult;
    logic [c_PROD_W-1:0]  r_acc;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_PROD_W-1:0]  r_product;

    state_t               w_state_nxt;
    logic [c_PROD_W-1:0]  w_mcand_nxt;
    logic [WIDTH-1:0]     w_mult_nxt;
    logic [c_PROD_W-1:0]  w_acc_nxt;
    logic [c_CNT_W-1:0]   w_count_nxt;
    logic [c_PROD_W-1:0]  w_product_nxt;

    logic [c_PROD_W-1:0]  w_pp;
    logic [c_PROD_W-1:0]  w_acc_sum;
    logic                 w_last;

    pp_and_row #(
        .W (c_PROD_W)
    ) u_pp_row (
        .i_vec (r_mcand),
        .i_en  (r_mult[0]),
        .o_pp  (w_pp)
    );

    // Cannot overflow: (2^W-1)^2 < 2^(2W).
    assign w_acc_sum = r_acc + w_pp;

`ifdef SEQ_MULT_EARLY_EXIT_EN
    // Finish once no set multiplier bits remain after this step's shift;
    // later steps would only add zero partial products.
    assign w_last = (r_count == c_LAST) || (r_mult[WIDTH-1:1] == '0);
`else
    assign w_last = (r_count == c_LAST);
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_mcand_nxt   = r_mcand;
        w_mult_nxt    = r_mult;
        w_acc_nxt     = r_acc;
        w_count_nxt   = r_count;
        w_product_nxt = r_product;

        case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_mcand_nxt = {{WIDTH{1'b0}}, bus.a};
                    w_mult_nxt  = bus.b;
                    w_acc_nxt   = '0;
                    w_count_nxt = '0;
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                // start is deliberately ignored here: operands stay latched.
                w_acc_nxt   = w_acc_sum;
                w_mcand_nxt = r_mcand << 1;
                w_mult_nxt  = r_mult >> 1;
                w_count_nxt = r_count + c_CNT_W'(1);
                if (w_last) begin
                    w_product_nxt = w_acc_sum;
                    w_state_nxt   = DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_mcand   <= '0;
            r_mult    <= '0;
            r_acc     <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_mcand   <= w_mcand_nxt;
            r_mult    <= w_mult_nxt;
            r_acc     <= w_acc_nxt;
            r_count   <= w_count_nxt;
            r_product <= w_product_nxt;
        end
    end

    assign bus.busy    = (r_state == RUN);
    assign bus.done    = (r_state == DONE);
    assign bus.product = r_product;

endmodule : seq_mult_unit
`default_nettype wire

// File: tb/tb_seq_mult_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_mult_unit
// Description : Self-checking bench for seq_mult_unit (WIDTH=8): directed
//               vector table, randomized jobs against a plain-arithmetic
//               reference, and hand-written back-to-back / mid-run start /
//               mid-run reset sequences. Honours SEQ_MULT_EARLY_EXIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mult_unit;

    localparam int WIDTH = 8;
    localparam int LIMIT = WIDTH + 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_mult_unit_if #(.WIDTH(WIDTH)) bus ();

    seq_mult_unit #(
        .WIDTH (WIDTH)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        int          lat_fix;
        int          lat_ee;
        int          poke;
    } vec_t;

    vec_t vec [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: product is ordinary integer multiplication.
    function automatic logic [15:0] ref_prod(input logic [7:0] av, input logic [7:0] bv);
        int p;
        p = int'(av) * int'(bv);
        return p[15:0];
    endfunction

    // Reference latency: WIDTH, or msb position + 1 (min 1) with early exit.
    function automatic int ref_lat(input logic [7:0] bv);
        int msb_lat;
        msb_lat = 1;
        for (int i = 0; i < WIDTH; i++)
            if (bv[i]) msb_lat = i + 1;
`ifdef SEQ_MULT_EARLY_EXIT_EN
        return msb_lat;
`else
        return (msb_lat > 0) ? WIDTH : 0;
`endif
    endfunction

    // Called at a negedge. Launches one job, optionally pokes start mid-run,
    // and checks latency, product, busy behaviour and the single done pulse.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic [15:0] exp_p, input int exp_lat,
                          input int poke, input string name);
        int   lat;
        int   extra;
        logic busy_ok;
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_v;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 8'($urandom);
        bus.b     = 8'($urandom);
        lat       = 0;
        busy_ok   = 1'b1;
        while (bus.done !== 1'b1 && lat < LIMIT) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (lat == poke) begin
                bus.start = 1'b1;
                bus.a     = 8'd5;
                bus.b     = 8'd5;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        chk({name, " latency"}, lat, exp_lat);
        chk({name, " product"}, 32'(bus.product), 32'(exp_p));
        chk({name, " busy_run"}, 32'(busy_ok), 1);
        chk({name, " busy_done"}, 32'(bus.busy), 0);
        @(negedge clk);
        chk({name, " done_low"}, 32'(bus.done), 0);
        chk({name, " hold"}, 32'(bus.product), 32'(exp_p));
        extra = 0;
        for (int i = 0; i < WIDTH + 2; i++) begin
            if (bus.done === 1'b1) extra++;
            @(negedge clk);
        end
        chk({name, " extra_done"}, extra, 0);
    endtask

    // Counts negedges from the current one until done is seen (bounded).
    task automatic wait_done(output int lat, output logic busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (bus.done !== 1'b1 && bus.busy !== 1'b1) busy_ok = 1'b0;
        end while (bus.done !== 1'b1 && lat < LIMIT + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          exp_lat;
        int          lat;
        int          dones;
        logic        busy_ok;
        logic [7:0]  ra;
        logic [7:0]  rb;

        vec[0] = '{8'd13,  8'd11,  16'd143,   8, 4, -1};
        vec[1] = '{8'd255, 8'd255, 16'hFE01,  8, 8, -1};
        vec[2] = '{8'd0,   8'd200, 16'd0,     8, 8,  3};
        vec[3] = '{8'd50,  8'd4,   16'd200,   8, 3, -1};
        vec[4] = '{8'd0,   8'd0,   16'd0,     8, 1, -1};
        vec[5] = '{8'd77,  8'd1,   16'd77,    8, 1, -1};
        vec[6] = '{8'd1,   8'd128, 16'd128,   8, 8, -1};
        vec[7] = '{8'd200, 8'd3,   16'd600,   8, 2, -1};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(bus.busy), 0);
        chk("reset done", 32'(bus.done), 0);
        chk("reset product", 32'(bus.product), 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
`ifdef SEQ_MULT_EARLY_EXIT_EN
            exp_lat = vec[i].lat_ee;
`else
            exp_lat = vec[i].lat_fix;
`endif
            run_op(vec[i].a, vec[i].b, vec[i].p, exp_lat, vec[i].poke,
                   $sformatf("vec%0d", i));
        end

        // Randomized jobs against the reference model.
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op(ra, rb, ref_prod(ra, rb), ref_lat(rb), -1, $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Back-to-back with start held; operands swapped in the DONE cycle.
        bus.start = 1'b1;
        bus.a     = 8'd3;
        bus.b     = 8'd7;
        wait_done(lat, busy_ok);
        chk("b2b first lat", lat, ref_lat(8'd7) + 1);
        chk("b2b first product", 32'(bus.product), 21);
        chk("b2b first busy_done", 32'(bus.busy), 0);
        bus.a = 8'd9;
        bus.b = 8'd9;
        wait_done(lat, busy_ok);
        chk("b2b done spacing", lat, ref_lat(8'd9) + 1);
        chk("b2b second product", 32'(bus.product), 81);
        chk("b2b busy between", 32'(busy_ok), 1);
        chk("b2b second busy_done", 32'(bus.busy), 0);
        bus.start = 1'b0;
        @(negedge clk);
        chk("b2b idle done", 32'(bus.done), 0);

        // Reset in the middle of a run.
        bus.start = 1'b1;
        bus.a     = 8'd100;
        bus.b     = 8'd100;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst busy", 32'(bus.busy), 0);
        chk("midrst done", 32'(bus.done), 0);
        chk("midrst product", 32'(bus.product), 0);
        rst   = 1'b0;
        dones = 0;
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        chk("midrst no done", dones, 0);
        chk("midrst idle busy", 32'(bus.busy), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_seq_mult_unit
`default_nettype wire
